// File: rtl/seg7_scan_decoder.sv
// Passive monitor for a multiplexed seven-segment bus: recovers the code on every
// digit once its pattern has been stable long enough, with frame and staleness status.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CAT_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [6:0]              cat_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_out,
    output logic                    stale_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    logic [6:0]            cat_s1_q, cat_s2_q;
    logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [6:0]            pat_q, pat_d;
    logic [IDX_W-1:0]      hidx_q, hidx_d;

    logic                  cap_q, cap_d;
    logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
    logic [3:0]            cap_code_q, cap_code_d;
    logic                  cap_err_q, cap_err_d;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] err_q, err_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  frame_q, frame_d;
    logic                  stale_q, stale_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] sel;
    logic                  one_hot;
    logic [IDX_W-1:0]      idx;
    logic                  match;
    logic [3:0]            code;
    logic                  unknown;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cat_s1_q <= '0;
            cat_s2_q <= '0;
            an_s1_q  <= '0;
            an_s2_q  <= '0;
        end else begin
            cat_s1_q <= cat_in;
            cat_s2_q <= cat_s1_q;
            an_s1_q  <= an_in;
            an_s2_q  <= an_s1_q;
        end
    end

    always_comb begin
        seg     = (CAT_ACTIVE_LOW != 0) ? ~cat_s2_q : cat_s2_q;
        sel     = (AN_ACTIVE_LOW != 0) ? ~an_s2_q : an_s2_q;
        one_hot = ($countones(sel) == 1);
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = IDX_W'(i);
        end
        match = (seg == pat_q) && (idx == hidx_q);
    end

    always_comb begin
        unknown = 1'b0;
        case (seg)
            7'h3F: code = 4'h0;
            7'h06: code = 4'h1;
            7'h5B: code = 4'h2;
            7'h4F: code = 4'h3;
            7'h66: code = 4'h4;
            7'h6D: code = 4'h5;
            7'h7D: code = 4'h6;
            7'h07: code = 4'h7;
            7'h7F: code = 4'h8;
            7'h6F: code = 4'h9;
            7'h77: code = 4'hA;
            7'h00: code = 4'hF;
            default: begin
                code    = 4'hE;
                unknown = 1'b1;
            end
        endcase
    end

    // Capture fires on the STABLE_CYCLES-th identical sample; HELD blocks re-capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        hidx_d     = hidx_q;
        cap_d      = 1'b0;
        cap_idx_d  = cap_idx_q;
        cap_code_d = cap_code_q;
        cap_err_d  = cap_err_q;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    state_d = SETTLE;
                    pat_d   = seg;
                    hidx_d  = idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!one_hot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (match) begin
                    if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        cap_d      = 1'b1;
                        cap_idx_d  = hidx_q;
                        cap_code_d = code;
                        cap_err_d  = unknown;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pat_d  = seg;
                    hidx_d = idx;
                    cnt_d  = CNT_W'(1);
                end
            end
            HELD: begin
                if (!one_hot) begin
                    state_d = IDLE;
                end else if (!match) begin
                    state_d = SETTLE;
                    pat_d   = seg;
                    hidx_d  = idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        frame_d  = &seen_q;
        seen_d   = (&seen_q) ? '0 : seen_q;
        stale_d  = stale_q;
        to_cnt_d = to_cnt_q;
        if (cap_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_idx_q == IDX_W'(i)) begin
                    digits_d[4*i +: 4] = cap_code_q;
                    valid_d[i]         = 1'b1;
                    err_d[i]           = cap_err_q;
                    seen_d[i]          = 1'b1;
                end
            end
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Codes survive a timeout so the last shown value stays inspectable.
            to_cnt_d = TO_W'(TIMEOUT_CYCLES);
            stale_d  = 1'b1;
            valid_d  = '0;
            seen_d   = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            hidx_q     <= '0;
            cap_q      <= 1'b0;
            cap_idx_q  <= '0;
            cap_code_q <= '0;
            cap_err_q  <= 1'b0;
            digits_q   <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            stale_q    <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            hidx_q     <= hidx_d;
            cap_q      <= cap_d;
            cap_idx_q  <= cap_idx_d;
            cap_code_q <= cap_code_d;
            cap_err_q  <= cap_err_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            stale_q    <= stale_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign digits_out = digits_q;
    assign valid_out  = valid_q;
    assign err_out    = err_q;
    assign frame_out  = frame_q;
    assign stale_out  = stale_q;

endmodule
